// File: rtl/rc5_pkg.sv
// -----------------------------------------------------------------------------
// rc5_pkg
// Shared definitions for the 16-bit RC5 block pair (w=8, r=1, 4-entry S table):
// word width, default subkeys (common to encryptor and decryptor) and the
// decryptor state encoding.
// -----------------------------------------------------------------------------
package rc5_pkg;

    localparam int W = 8;

    // Default subkey table shared with the encryptor.
    localparam logic [W-1:0] S0_DEF = 8'h20;   // whitening for A
    localparam logic [W-1:0] S1_DEF = 8'h10;   // whitening for B
    localparam logic [W-1:0] S2_DEF = 8'hFF;   // round key for A
    localparam logic [W-1:0] S3_DEF = 8'hFF;   // round key for B

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RND_B = 3'd1,
        RND_A = 3'd2,
        WHT   = 3'd3,
        HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/rc5_dec_16bit_if.sv
// -----------------------------------------------------------------------------
// rc5_dec_16bit_if
// Handshake bundle for the RC5 decryptor.
//   in_valid/in_ready/c    : ciphertext input channel
//   out_valid/out_ready/p  : plaintext output channel
//   busy                   : decryptor FSM not idle
// master = ciphertext source / plaintext sink, slave = decryptor.
// -----------------------------------------------------------------------------
interface rc5_dec_16bit_if;

    logic                       in_valid;
    logic                       in_ready;
    logic [2*rc5_pkg::W-1:0]    c;
    logic                       out_valid;
    logic                       out_ready;
    logic [2*rc5_pkg::W-1:0]    p;
    logic                       busy;

    modport master (
        output in_valid, c, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, c, out_ready,
        output in_ready, out_valid, p, busy
    );

endinterface

// File: rtl/rc5_rotr8.sv
// -----------------------------------------------------------------------------
// rc5_rotr8
// Combinational 8-bit rotate right.
//   x : word to rotate
//   n : rotate amount (already reduced mod 8)
//   y : rotated word
// Rotating the doubled word avoids the shift-by-8 corner case when n == 0.
// -----------------------------------------------------------------------------
module rc5_rotr8
    import rc5_pkg::*;
(
    input  logic [W-1:0] x,
    input  logic [2:0]   n,
    output logic [W-1:0] y
);

    assign y = W'({x, x} >> n);

endmodule

// File: rtl/rc5_dec_16bit.sv
// -----------------------------------------------------------------------------
// rc5_dec_16bit
// Sequential 16-bit RC5 decryptor (w=8, r=1). Runs the inverse round for B,
// then A, then removes the whitening, and holds the plaintext until taken.
//   clock : rising-edge clock
//   reset : synchronous, active-low
//   bus   : rc5_dec_16bit_if.slave (in_valid/in_ready/c, out_valid/out_ready/p,
//           busy)
// Optional build macro RC5_DEC_SKID_EN: adds a 2-entry input FIFO so up to two
// words are absorbed while the FSM is busy or stalled in HOLD.
// -----------------------------------------------------------------------------
module rc5_dec_16bit
    import rc5_pkg::*;
#(
    parameter logic [W-1:0] S0 = S0_DEF,
    parameter logic [W-1:0] S1 = S1_DEF,
    parameter logic [W-1:0] S2 = S2_DEF,
    parameter logic [W-1:0] S3 = S3_DEF
) (
    input  logic            clock,
    input  logic            reset,
    rc5_dec_16bit_if.slave  bus
);

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [2*W-1:0]   p_q;
    logic             out_valid_q;

    // Word presented to the FSM and the condition that loads it.
    logic             start;
    logic [2*W-1:0]   start_word;

    // Inverse round datapath. RND_A sees the B already updated in RND_B.
    logic [W-1:0]     b_sub;
    logic [W-1:0]     a_sub;
    logic [W-1:0]     b_rot;
    logic [W-1:0]     a_rot;

    assign b_sub = b - S3;
    assign a_sub = a - S2;

    rc5_rotr8 u_rotr_b (.x(b_sub), .n(a[2:0]), .y(b_rot));
    rc5_rotr8 u_rotr_a (.x(a_sub), .n(b[2:0]), .y(a_rot));

`ifdef RC5_DEC_SKID_EN
    logic [2*W-1:0]   fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       fifo_cnt;
    logic             push;
    logic             pop;

    assign push       = bus.in_valid && (fifo_cnt != 2'd2);
    assign pop        = (state == IDLE) && (fifo_cnt != 2'd0);
    assign start      = pop;
    assign start_word = fifo_mem[rd_ptr];
    assign bus.in_ready = (fifo_cnt != 2'd2);

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
        end
    end

    // NOTE: storage is not reset; emptiness is tracked by fifo_cnt alone, so
    // stale entries are never observed and the array stays plain RAM/flops.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= bus.c;
    end
`else
    assign start        = (state == IDLE) && bus.in_valid;
    assign start_word   = bus.c;
    assign bus.in_ready = (state == IDLE);
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: next state defaults to the current state before the case, so no
    // path leaves state_nxt unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RND_B;
            RND_B:   state_nxt = RND_A;
            RND_A:   state_nxt = WHT;
            WHT:     state_nxt = HOLD;
            HOLD:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            a           <= '0;
            b           <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a <= start_word[2*W-1:W];
                        b <= start_word[W-1:0];
                    end
                end
                RND_B: b <= b_rot ^ a;
                RND_A: a <= a_rot ^ b;
                WHT: begin
                    p_q         <= {a - S0, b - S1};
                    out_valid_q <= 1'b1;
                end
                HOLD: if (bus.out_ready) out_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.p         = p_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_rc5_dec_16bit.sv
// -----------------------------------------------------------------------------
// tb_rc5_dec_16bit
// Directed bench for rc5_dec_16bit with hand-computed plaintexts:
//   2F9E -> 0000 (rotate-by-0 in RND_A), 6687 -> 1234.
// Covers reset state, latency, back-to-back throughput, HOLD stall, reset in
// mid-operation and, when RC5_DEC_SKID_EN is defined, FIFO fill and ordering.
// -----------------------------------------------------------------------------
module tb_rc5_dec_16bit;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    rc5_dec_16bit_if bus_if ();

    rc5_dec_16bit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

`ifdef RC5_DEC_SKID_EN
    localparam int LAT = 5;   // one extra edge through the FIFO
`else
    localparam int LAT = 4;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] got_q [$];

    // Record every plaintext handed over (valid and ready at the next edge).
    always @(negedge clock) begin
        if (reset && bus_if.out_valid && bus_if.out_ready)
            got_q.push_back(bus_if.p);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one word, let it be accepted, then count edges until out_valid.
    task automatic send_word(input logic [15:0] cv, output int lat);
        int budget;
        budget = 0;
        while (!bus_if.in_ready && budget < 20) begin
            tick();
            budget++;
        end
        if (!bus_if.in_ready) check("send_rdy_timeout", 0, 1);
        bus_if.c        = cv;
        bus_if.in_valid = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
        lat = 1;
        while (!bus_if.out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int k;
        int n_acc;
        int t_acc [2];
        logic acc;

        bus_if.in_valid  = 1'b0;
        bus_if.c         = '0;
        bus_if.out_ready = 1'b0;

        // Reset state.
        reset = 1'b0;
        tick();
        tick();
        check("rst_in_ready",  bus_if.in_ready,  1);
        check("rst_busy",      bus_if.busy,      0);
        check("rst_out_valid", bus_if.out_valid, 0);
        check("rst_p",         bus_if.p,         16'h0000);
        reset = 1'b1;
        tick();

        // 2F9E -> 0000, exercises rotate by 0 in RND_A.
        send_word(16'h2F9E, lat);
        check("t1_latency",   lat,              LAT);
        check("t1_out_valid", bus_if.out_valid, 1);
        check("t1_p",         bus_if.p,         16'h0000);
        check("t1_busy",      bus_if.busy,      1);
`ifndef RC5_DEC_SKID_EN
        check("t1_in_ready",  bus_if.in_ready,  0);
`endif
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
        check("t1_done_valid", bus_if.out_valid, 0);
        check("t1_done_busy",  bus_if.busy,      0);

        // 6687 -> 1234, then a 10-cycle stall in HOLD.
        send_word(16'h6687, lat);
        check("t2_latency", lat,      LAT);
        check("t2_p",       bus_if.p, 16'h1234);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_p",     bus_if.p,         16'h1234);
            check("stall_valid", bus_if.out_valid, 1);
`ifndef RC5_DEC_SKID_EN
            check("stall_in_ready", bus_if.in_ready, 0);
`endif
        end
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
        check("release_valid",    bus_if.out_valid, 0);
        check("release_busy",     bus_if.busy,      0);
        check("release_in_ready", bus_if.in_ready,  1);

        // Back-to-back 2F9E then 6687 with the sink always ready.
        got_q.delete();
        bus_if.out_ready = 1'b1;
        bus_if.c         = 16'h2F9E;
        bus_if.in_valid  = 1'b1;
        n_acc = 0;
        t_acc[0] = 0;
        t_acc[1] = 0;
        for (k = 0; k < 40; k++) begin
            acc = bus_if.in_ready && bus_if.in_valid;
            tick();
            if (acc) begin
                t_acc[n_acc] = k;
                n_acc++;
                if (n_acc == 1) bus_if.c = 16'h6687;
                else            bus_if.in_valid = 1'b0;
            end
            if (n_acc == 2 && got_q.size() == 2) break;
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        check("b2b_accepts", n_acc,        2);
        check("b2b_outputs", got_q.size(), 2);
`ifndef RC5_DEC_SKID_EN
        check("b2b_gap", t_acc[1] - t_acc[0], 5);
`endif
        if (got_q.size() >= 2) begin
            check("b2b_first",  got_q[0], 16'h0000);
            check("b2b_second", got_q[1], 16'h1234);
        end

        // Reset asserted while in RND_A.
        tick();
        bus_if.c        = 16'h6687;
        bus_if.in_valid = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
        repeat (LAT - 3) tick();
        check("midrst_busy_before", bus_if.busy, 1);
        reset = 1'b0;
        tick();
        check("midrst_out_valid", bus_if.out_valid, 0);
        check("midrst_p",         bus_if.p,         16'h0000);
        check("midrst_in_ready",  bus_if.in_ready,  1);
        check("midrst_busy",      bus_if.busy,      0);
        reset = 1'b1;
        tick();
        send_word(16'h6687, lat);
        check("post_rst_latency", lat,      LAT);
        check("post_rst_p",       bus_if.p, 16'h1234);
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;

`ifdef RC5_DEC_SKID_EN
        // Three words pushed on consecutive cycles fill the FIFO.
        begin
            logic [15:0] words [3];
            logic [15:0] expw  [3];
            words[0] = 16'h2F9E; expw[0] = 16'h0000;
            words[1] = 16'h6687; expw[1] = 16'h1234;
            words[2] = 16'h2F9E; expw[2] = 16'h0000;
            got_q.delete();
            bus_if.out_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                check("skid_rdy", bus_if.in_ready, 1);
                bus_if.c        = words[i];
                bus_if.in_valid = 1'b1;
                tick();
            end
            bus_if.in_valid = 1'b0;
            check("skid_full", bus_if.in_ready, 0);
            k = 0;
            while (got_q.size() < 3 && k < 60) begin
                tick();
                k++;
            end
            bus_if.out_ready = 1'b0;
            check("skid_outputs", got_q.size(), 3);
            if (got_q.size() >= 3) begin
                for (int i = 0; i < 3; i++)
                    check("skid_word", got_q[i], expw[i]);
            end
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rc5_dec_16bit.md
# rc5_dec_16bit

Downstream stage of the 16-bit RC5 encryptor (w=8, r=1, 4-entry S table). Takes the 16-bit ciphertext it produces, runs the inverse round and whitening sequentially, and returns the plaintext. Uses a valid/ready handshake on both sides, so it can be chained after the encryptor or fed from a bus.

## Interface
- S0, 8'h20: subkey S[0], whitening for A.
- S1, 8'h10: subkey S[1], whitening for B.
- S2, 8'hFF: subkey S[2], round key for A.
- S3, 8'hFF: subkey S[3], round key for B.
- clock, in, 1, rising-edge clock.
- reset, in, 1, synchronous, active-low.
- in_valid, in, 1, ciphertext word present.
- in_ready, out, 1, block can accept; 1 only in IDLE.
- c, in, 16, ciphertext; A=c[15:8], B=c[7:0].
- out_valid, out, 1, plaintext available.
- out_ready, in, 1, sink accepts plaintext.
- p, out, 16, recovered plaintext.
- busy, out, 1, state != IDLE.

## Operation
- All arithmetic is 8-bit modulo 256.
- rotr(x,n) rotates right by n%8. A rotation of 0 returns x unchanged, with no shift-by-8 artefact.
- State sequence: IDLE -> RND_B -> RND_A -> WHT -> HOLD -> IDLE.
- IDLE: in_ready=1. When in_valid is high, the next edge loads A<=c[15:8], B<=c[7:0] and moves to RND_B.
- RND_B: B <= rotr(B - S3, A) ^ A.
- RND_A: A <= rotr(A - S2, B) ^ B. Uses the B value updated in RND_B.
- WHT: p <= {A - S0, B - S1}. out_valid is set to 1 on this edge.
- HOLD: p and out_valid are held stable until out_ready is high. The edge with out_ready=1 clears out_valid and returns to IDLE.
- in_valid seen outside IDLE is ignored, because in_ready=0 there.
- Reset, including mid-operation: state=IDLE, A=B=0, p=16'h0000, out_valid=0, in_ready=1, busy=0. A partially processed block is discarded.
- No implicit latching: p changes only on the WHT edge or on reset.

## Timing
- Accept edge T0 (IDLE with in_valid=1).
- RND_B computed at T1, RND_A at T2, WHT at T3. out_valid is first seen high after T3: latency 4 edges.
- Earliest completion: out_ready=1 at T4, so IDLE is entered at T4 and in_ready=1 from T4.
- Next accept at T5. Peak throughput is 1 word per 5 cycles.
- out_ready held low leaves the block stalling indefinitely in HOLD with outputs stable.
- Outputs are registered; no combinational path from c to p. in_ready and busy are decoded from state only.

## Configuration
- RC5_DEC_SKID_EN defined:
  - A 2-entry input FIFO sits in front of the FSM. in_ready is 1 whenever the FIFO is not full.
  - The FSM pops from the FIFO in IDLE. A push and a pop on the same edge keep the count unchanged.
  - A push when full cannot occur, because in_ready=0 when full.
  - Reset empties the FIFO.
  - Throughput per word is unchanged, but up to 2 words are absorbed while the FSM is busy or HOLD stalls.
- RC5_DEC_SKID_EN undefined: no FIFO; in_ready behaves exactly as described above.

## Structure
- Shared package rc5_pkg holds:
  - default subkey constants, also used by the encryptor;
  - the state enum typedef (IDLE, RND_B, RND_A, WHT, HOLD);
  - the word-width localparam W=8.
- Sub-module rc5_rotr8 is combinational: x[7:0], n[2:0] -> y[7:0]. It is instantiated twice, once for RND_B and once for RND_A.
- The skid FIFO is inline and `ifdef-guarded; it is not a separate module.

## Test plan
- Reset, then c=16'h2F9E with in_valid held for one accepted cycle -> out_valid after 4 edges, p=16'h0000. Covers the rotate-by-0 path in RND_A.
- c=16'h6687 -> p=16'h1234.
- Back-to-back c=2F9E, then 6687, with out_ready=1 -> second accept no earlier than 5 cycles after the first. Outputs 0000 then 1234, in order.
- out_ready=0 for 10 cycles after out_valid -> p stable, in_ready=0 throughout. Release -> IDLE on the next edge.
- reset=0 asserted in RND_A -> next edge: out_valid=0, p=0000, in_ready=1. A fresh c=6687 then yields 1234.
- With RC5_DEC_SKID_EN: three words pushed on consecutive cycles -> in_ready drops after the FIFO fills. All three decrypt correctly in order.
